// File: rtl/avmm_reg_responder_if.sv
// Avalon-MM register-bus bundle between the controller's 8-bit avm_m0
// master and the avmm_reg_responder slave.
//   avs_address        8  register address (master -> slave)
//   avs_read           1  read request, held while waitrequest=1
//   avs_write          1  write request, held while waitrequest=1
//   avs_writedata      8  write data
//   avs_waitrequest    1  1 = command not yet accepted (slave -> master)
//   avs_readdata       8  read data, zero unless readdatavalid
//   avs_readdatavalid  1  one-cycle read response strobe
interface avmm_reg_responder_if;
  logic [7:0] avs_address;
  logic       avs_read;
  logic       avs_write;
  logic [7:0] avs_writedata;
  logic       avs_waitrequest;
  logic [7:0] avs_readdata;
  logic       avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_waitrequest, avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_waitrequest, avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/avmm_reg_responder.sv
// Avalon-MM register responder: 8-bit register bank with ID, sticky events
// (W1C), irq mask, RW control regs, error counter and RO status regs.
// Ports:
//   clk       single clock, rising edge
//   reset_n   asynchronous active-low reset
//   avs       avmm_reg_responder_if.slave register bus
//   sts_in    live status, reg k = sts_in[8k+7:8k] at 0x80+k
//   sts_evt   event pulses setting sticky bits
//   ctrl_out  control regs, reg k = ctrl_out[8k+7:8k] at 0x03+k
//   irq       registered |(sticky & irq_mask)
//
// state  | meaning
// S_IDLE | no command pending, waitrequest high
// S_WAIT | command seen, counting WAIT_CYC stall cycles
// S_ACK  | waitrequest low for one cycle, command sampled here
module avmm_reg_responder #(
  parameter logic [7:0] BLOCK_ID = 8'hA5,
  parameter int NCTRL    = 8,
  parameter int NSTS     = 4,
  parameter int WAIT_CYC = 1,
  parameter int READ_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avmm_reg_responder_if.slave  avs,
  input  logic [8*NSTS-1:0]    sts_in,
  input  logic [7:0]           sts_evt,
  output logic [8*NCTRL-1:0]   ctrl_out,
  output logic                 irq
);
  localparam logic [7:0] CTRL_END = 8'(3 + NCTRL);
  localparam logic [7:0] STS_END  = 8'(128 + NSTS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       req;

  assign req = avs.avs_read | avs.avs_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall counter loads WAIT_CYC on entry and leaves at terminal count 1.
  // A request that vanishes before ACK is dropped without side effects.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYC == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYC);
          end
        end
      end
      S_WAIT: begin
        if (!req)                state_d = S_IDLE;
        else if (cnt_q == 4'd1)  state_d = S_ACK;
        else                     cnt_d   = cnt_q - 4'd1;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    avs.avs_waitrequest = (state_q != S_ACK);
  end

  // Accept decode; read+write together is handled as a write.
  logic       acc, acc_wr, acc_rd;
  logic [7:0] addr, wdata, ctrl_idx, sts_idx;
  logic       is_id, is_sticky, is_mask, is_ctrl, is_err, is_sts, mapped, ro;

  assign acc    = (state_q == S_ACK) && req;
  assign acc_wr = acc && avs.avs_write;
  assign acc_rd = acc && avs.avs_read && !avs.avs_write;
  assign addr   = avs.avs_address;
  assign wdata  = avs.avs_writedata;

  assign is_id     = (addr == 8'h00);
  assign is_sticky = (addr == 8'h01);
  assign is_mask   = (addr == 8'h02);
  assign is_ctrl   = (addr >= 8'h03) && (addr < CTRL_END);
  assign is_err    = (addr == 8'h7F);
  assign is_sts    = (addr >= 8'h80) && (addr < STS_END);
  assign mapped    = is_id | is_sticky | is_mask | is_ctrl | is_err | is_sts;
  assign ro        = is_id | is_sts;
  assign ctrl_idx  = addr - 8'h03;
  assign sts_idx   = addr - 8'h80;

  logic [7:0] sticky_q, mask_q, err_q, sticky_d, rd_val;
  logic       err_inc, err_clr;

  assign err_inc = acc && (!mapped || (avs.avs_write && ro) ||
                           (avs.avs_read && avs.avs_write));
  assign err_clr = acc_wr && is_err;

  // Set wins over a same-cycle W1C clear.
  assign sticky_d = (sticky_q & ~((acc_wr && is_sticky) ? wdata : 8'h00)) | sts_evt;

  always_comb begin
    rd_val = 8'h00;
    if (is_id)          rd_val = BLOCK_ID;
    else if (is_sticky) rd_val = sticky_q;
    else if (is_mask)   rd_val = mask_q;
    else if (is_err)    rd_val = err_q;
    for (int k = 0; k < NCTRL; k++)
      if (is_ctrl && ctrl_idx == 8'(k)) rd_val = ctrl_out[8*k +: 8];
    for (int k = 0; k < NSTS; k++)
      if (is_sts && sts_idx == 8'(k)) rd_val = sts_in[8*k +: 8];
  end

  // Read response pipeline; data is forced to zero in empty slots so the
  // output is zero whenever readdatavalid is low.
  logic [READ_LAT-1:0] vld_q;
  logic [7:0]          dat_q [READ_LAT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sticky_q <= 8'h00;
      mask_q   <= 8'h00;
      err_q    <= 8'h00;
      ctrl_out <= '0;
      irq      <= 1'b0;
      vld_q    <= '0;
      for (int k = 0; k < READ_LAT; k++) dat_q[k] <= 8'h00;
    end else begin
      sticky_q <= sticky_d;
      irq      <= |(sticky_q & mask_q);
      if (acc_wr && is_mask) mask_q <= wdata;
      for (int k = 0; k < NCTRL; k++)
        if (acc_wr && is_ctrl && ctrl_idx == 8'(k)) ctrl_out[8*k +: 8] <= wdata;
      if (err_clr)                        err_q <= err_inc ? 8'h01 : 8'h00;
      else if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'h01;
      vld_q[0] <= acc_rd;
      dat_q[0] <= acc_rd ? rd_val : 8'h00;
      for (int k = 1; k < READ_LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

  assign avs.avs_readdatavalid = vld_q[READ_LAT-1];
  assign avs.avs_readdata      = dat_q[READ_LAT-1];
endmodule
